hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Sequences the decode stage: decides each cycle whether decode may advance, must stall, or
//  must kill the fetched instruction. Tracks in-flight register writes in EX/MEM/WB with a
//  3-slot scoreboard, drives operand forwarding selects, detects load-use hazards, and owns
//  the multi-cycle mult/div busy counter. Sits beside the decode module; its outputs drive
//  the enables of the fetch/decode pipeline registers and the operand A/B forwarding muxes.
// PARAMETERS
//  MULDIV_CYCLES  32  cycles a mult/div occupies HI/LO after issue (>=1)
//  DELAY_SLOT     0   1: instruction after a taken branch/jump executes; 0: it is flushed
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   asynchronous, active-high
//  dec_valid        in   1   decode holds a real instruction (not a bubble)
//  dec_rs           in   5   source register A of decoding instruction
//  dec_rt           in   5   source register B
//  dec_uses_rs      in   1   instruction reads rs
//  dec_uses_rt      in   1   instruction reads rt
//  dec_dest         in   5   write destination (after rt/rd/$31 select)
//  dec_reg_write    in   1   instruction writes the register file
//  dec_is_load      in   1   result comes from data memory
//  dec_is_muldiv    in   1   instruction starts a mult/div
//  dec_reads_hilo   in   1   instruction is mfhi/mflo
//  dec_redirect     in   1   taken branch or jump resolved in decode this cycle
//  stall            out  1   hold PC and fetch/decode registers; insert bubble into EX
//  flush_fetch      out  1   replace fetched instruction with a bubble at next edge
//  fwd_a_sel        out  2   operand A source: 0 regfile, 1 EX, 2 MEM, 3 WB
//  fwd_b_sel        out  2   operand B source, same encoding
//  muldiv_busy      out  1   HI/LO not yet valid
// BEHAVIOUR
//  Reset: all scoreboard slots invalid, busy counter 0; stall=0, flush_fetch=0, fwd_*=0,
//   muldiv_busy=0. Reset asserted mid-mult/div abandons it (counter -> 0 immediately).
//  Scoreboard slot = {valid, dest[4:0], is_load}. Entry from decode is valid only when
//   dec_valid & dec_reg_write & dec_dest!=0. Every edge: WB<=MEM, MEM<=EX; EX<=entry when
//   stall=0, else EX<=invalid (bubble). Scoreboard never holds; no enable input.
//  Forwarding (combinational, per operand, only when dec_uses_* and source!=0): first match
//   of EX (non-load only), MEM, WB by dest; none -> 0. Register $0 always selects 0.
//  Load-use stall: EX.valid & EX.is_load & dest matches a used source -> stall=1 for that
//   cycle; next cycle the load is in MEM and forwarding selects 2. Exactly one stall cycle.
//  Mult/div: counter loads MULDIV_CYCLES on an edge where dec_valid & dec_is_muldiv &
//   stall=0; else decrements while nonzero. muldiv_busy = (counter!=0).
//   dec_valid & (dec_reads_hilo | dec_is_muldiv) & muldiv_busy -> stall=1. Back-to-back
//   mult/div therefore issues on the first cycle busy=0.
//  stall = load_use | hilo_stall; no stall without dec_valid.
//  Redirect: flush_fetch = dec_redirect & dec_valid & ~stall & (DELAY_SLOT==0).
//   Redirect during stall is ignored; decode re-presents the branch once operands are ready.
//  Latency: all outputs combinational from inputs + state; state updates on rising clk.
//  Counter width = $clog2(MULDIV_CYCLES+1); no wrap (saturates at 0).
// STRUCTURE
//  Shared header mips_defs.vh: FWD_REG/FWD_EX/FWD_MEM/FWD_WB encodings, scoreboard slot
//   field offsets and width, default MULDIV_CYCLES; decode and ALU muxes include the same.
//  One sub-module: muldiv_busy_counter (load, count-down, busy flag, async reset).
//  Scoreboard, compare and forwarding priority logic stay flat in this module.
// TESTING
//  1 addu $3,$1,$2 then addu $4,$3,$3 -> fwd_a_sel=fwd_b_sel=1, stall=0.
//  2 lw $5,0($1) then addu $6,$5,$0 -> stall=1 one cycle, next cycle fwd_a_sel=2, fwd_b_sel=0.
//  3 Write to $0 followed by read of $0 -> fwd_*=0, no stall at any distance.
//  4 mult at t, mflo at t+1 (MULDIV_CYCLES=4) -> stall cycles t+1..t+4, mflo issues t+5.
//  5 Taken beq with DELAY_SLOT=0 -> flush_fetch=1 one cycle; same beq during a load-use
//    stall -> flush_fetch=0 until the stall clears.
//  6 Assert reset mid-mult/div and with EX holding a load -> all outputs 0 asynchronously,
//    no stall on first post-reset instruction.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared encodings and scoreboard slot layout for the decode hazard logic.
// Decode and the ALU operand muxes import the same forwarding encodings.
package hazard_controller_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int DEFAULT_MULDIV_CYCLES = 32;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_slot_t;

  localparam int SLOT_W = $bits(sb_slot_t);

  function automatic logic slot_hit(input sb_slot_t slot, input logic [4:0] src);
    return slot.valid && (slot.dest == src);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side bundle: instruction attributes in, pipeline control and forwarding selects out.
interface hazard_controller_if;
  logic       dec_valid;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       dec_uses_rs;
  logic       dec_uses_rt;
  logic [4:0] dec_dest;
  logic       dec_reg_write;
  logic       dec_is_load;
  logic       dec_is_muldiv;
  logic       dec_reads_hilo;
  logic       dec_redirect;
  logic       stall;
  logic       flush_fetch;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       muldiv_busy;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_dest,
           dec_reg_write, dec_is_load, dec_is_muldiv, dec_reads_hilo, dec_redirect,
    input  stall, flush_fetch, fwd_a_sel, fwd_b_sel, muldiv_busy
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_dest,
           dec_reg_write, dec_is_load, dec_is_muldiv, dec_reads_hilo, dec_redirect,
    output stall, flush_fetch, fwd_a_sel, fwd_b_sel, muldiv_busy
  );
endinterface

// File: rtl/hazard_controller_muldiv.sv
// HI/LO busy counter: loads on mult/div issue, counts down to zero, never wraps.
module muldiv_busy_counter #(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= CW'(CYCLES);
    else if (cnt != '0)    cnt <= cnt - CW'(1);
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard control: EX/MEM/WB write scoreboard, operand forwarding,
// load-use and HI/LO interlocks, and fetch flush on redirect.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MULDIV_CYCLES = DEFAULT_MULDIV_CYCLES,
  parameter bit DELAY_SLOT    = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  sb_slot_t sb_ex, sb_mem, sb_wb, entry;
  logic     load_use, hilo_stall, stall_int, busy, muldiv_load;
  logic [1:0] sel_a, sel_b;

  // EX is skipped for loads: their data is not ready until MEM, load_use covers that case.
  function automatic logic [1:0] fwd_pick(input logic use_src, input logic [4:0] src,
                                          input sb_slot_t ex, input sb_slot_t mem,
                                          input sb_slot_t wb);
    logic [1:0] sel;
    sel = FWD_REG;
    if (use_src && src != 5'd0) begin
      if (slot_hit(ex, src) && !ex.is_load) sel = FWD_EX;
      else if (slot_hit(mem, src))          sel = FWD_MEM;
      else if (slot_hit(wb, src))           sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    entry.valid   = hz.dec_valid && hz.dec_reg_write && (hz.dec_dest != 5'd0);
    entry.dest    = hz.dec_dest;
    entry.is_load = hz.dec_is_load;
  end

  assign sel_a = fwd_pick(hz.dec_uses_rs, hz.dec_rs, sb_ex, sb_mem, sb_wb);
  assign sel_b = fwd_pick(hz.dec_uses_rt, hz.dec_rt, sb_ex, sb_mem, sb_wb);

  assign load_use = hz.dec_valid && sb_ex.is_load &&
                    ((hz.dec_uses_rs && hz.dec_rs != 5'd0 && slot_hit(sb_ex, hz.dec_rs)) ||
                     (hz.dec_uses_rt && hz.dec_rt != 5'd0 && slot_hit(sb_ex, hz.dec_rt)));

  assign hilo_stall  = hz.dec_valid && (hz.dec_reads_hilo || hz.dec_is_muldiv) && busy;
  assign stall_int   = load_use || hilo_stall;
  assign muldiv_load = hz.dec_valid && hz.dec_is_muldiv && !stall_int;

  // A stalled decode sends a bubble into EX; older slots always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= stall_int ? sb_slot_t'('0) : entry;
    end
  end

  muldiv_busy_counter #(.CYCLES(MULDIV_CYCLES)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .load  (muldiv_load),
    .busy  (busy)
  );

  // Outputs are forced quiet while reset is held, regardless of decode inputs.
  assign hz.stall       = !reset && stall_int;
  assign hz.flush_fetch = !reset && hz.dec_redirect && hz.dec_valid && !stall_int &&
                          (DELAY_SLOT == 1'b0);
  assign hz.fwd_a_sel   = reset ? FWD_REG : sel_a;
  assign hz.fwd_b_sel   = reset ? FWD_REG : sel_b;
  assign hz.muldiv_busy = busy;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MULDIV_CYCLES=4, DELAY_SLOT=0.
module tb_hazard_controller;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs = 0;

  hazard_controller_if hif();

  hazard_controller #(.MULDIV_CYCLES(4), .DELAY_SLOT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic ld, input logic md,
                       input logic hilo, input logic redir);
    hif.dec_valid      = v;
    hif.dec_rs         = rs;
    hif.dec_rt         = rt;
    hif.dec_uses_rs    = urs;
    hif.dec_uses_rt    = urt;
    hif.dec_dest       = dest;
    hif.dec_reg_write  = rw;
    hif.dec_is_load    = ld;
    hif.dec_is_muldiv  = md;
    hif.dec_reads_hilo = hilo;
    hif.dec_redirect   = redir;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic f,
                         input logic [1:0] a, input logic [1:0] b, input logic busy);
    chk({tag, ".stall"}, {1'b0, hif.stall}, {1'b0, s});
    chk({tag, ".flush"}, {1'b0, hif.flush_fetch}, {1'b0, f});
    chk({tag, ".fwd_a"}, hif.fwd_a_sel, a);
    chk({tag, ".fwd_b"}, hif.fwd_b_sel, b);
    chk({tag, ".busy"},  {1'b0, hif.muldiv_busy}, {1'b0, busy});
  endtask

  // Inputs are driven 1 after the edge; check 2 later, then advance one cycle.
  task automatic step(input string tag, input logic s, input logic f,
                      input logic [1:0] a, input logic [1:0] b, input logic busy);
    #2;
    chk_all(tag, s, f, a, b, busy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    #3;
    chk_all("reset", 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // addu $3,$1,$2 ; addu $4,$3,$3 ; sw-like read $3,$4 ; read $3,$4 again
    drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 0); step("t1_first", 0, 0, 0, 0, 0);
    drive(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 0); step("t1_ex", 0, 0, 1, 1, 0);
    drive(1, 5'd3, 5'd4, 1, 1, 5'd0, 0, 0, 0, 0, 0); step("t1_mem_ex", 0, 0, 2, 1, 0);
    drive(1, 5'd3, 5'd4, 1, 1, 5'd5, 0, 0, 0, 0, 0); step("t1_wb_mem", 0, 0, 3, 2, 0);
    for (int i = 0; i < 3; i++) begin bubble(); step("drain1", 0, 0, 0, 0, 0); end

    // lw $5,0($1) ; addu $6,$5,$0
    drive(1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 0); step("t2_lw", 0, 0, 0, 0, 0);
    drive(1, 5'd5, 5'd0, 1, 1, 5'd6, 1, 0, 0, 0, 0); step("t2_stall", 1, 0, 0, 0, 0);
    step("t2_after", 0, 0, 2, 0, 0);
    bubble(); step("t2_bub", 0, 0, 0, 0, 0);

    // writes to $0 (ALU and load) never forward or stall
    drive(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0, 0, 0); step("t3_w0", 0, 0, 0, 0, 0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 0); step("t3_lw0", 0, 0, 0, 0, 0);
    drive(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0, 0, 0); step("t3_r0a", 0, 0, 0, 0, 0);
    step("t3_r0b", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin bubble(); step("drain3", 0, 0, 0, 0, 0); end

    // mult at t, mflo from t+1: stalls t+1..t+4, issues t+5
    drive(1, 5'd7, 5'd8, 1, 1, 5'd0, 0, 0, 1, 0, 0); step("t4_mult", 0, 0, 0, 0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("t4_mflo_stall", 1, 0, 0, 0, 1);
    step("t4_mflo_issue", 0, 0, 0, 0, 0);
    bubble(); step("t4_bub", 0, 0, 0, 0, 0);

    // taken beq flushes; same beq behind a load-use stall waits
    drive(1, 5'd10, 5'd11, 1, 1, 5'd0, 0, 0, 0, 0, 1); step("t5_beq", 0, 1, 0, 0, 0);
    bubble(); step("t5_bub", 0, 0, 0, 0, 0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd12, 1, 1, 0, 0, 0); step("t5_lw", 0, 0, 0, 0, 0);
    drive(1, 5'd12, 5'd11, 1, 1, 5'd0, 0, 0, 0, 0, 1); step("t5_beq_stall", 1, 0, 0, 0, 0);
    step("t5_beq_go", 0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin bubble(); step("drain5", 0, 0, 0, 0, 0); end

    // reset mid-mult with a load in EX
    drive(1, 5'd7, 5'd8, 1, 1, 5'd0, 0, 0, 1, 0, 0); step("t6_mult", 0, 0, 0, 0, 0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd13, 1, 1, 0, 0, 0); step("t6_lw", 0, 0, 0, 0, 1);
    drive(1, 5'd13, 5'd0, 1, 1, 5'd14, 1, 0, 0, 0, 0);
    #2;
    chk_all("t6_pre", 1, 0, 0, 0, 1);
    reset = 1'b1;
    #1;
    chk_all("t6_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("t6_post", 0, 0, 0, 0, 0);
    drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 0, 1, 0); step("t6_mfhi", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
